filter_channel_scheduler: RTL and testbench

Time-multiplexes one first-order fixed-point filter datapath across `CHANNELS` suspension sensor streams. Each channel offers samples on a valid/ready handshake. A round-robin arbiter picks one channel and a 4-state FSM runs that channel's filter update. Per-channel state (last and previous output) lives in local registers, and each result is presented on a single output stream tagged with its channel number. It sits between the sensor front-ends and the suspension controller, replacing one filter instance per channel.

---
 rtl/filter_sched_pkg.sv | 32 +++
 rtl/filter_channel_scheduler_arb.sv | 57 +++++
 rtl/filter_channel_scheduler.sv | 168 ++++++++++++++++
 tb/tb_filter_channel_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_sched_pkg.sv
// Shared types and helpers for the multi-channel filter scheduler.
// Holds the FSM state enum, width constants and the shift helper.
package filter_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        WRITE,
        HOLD
    } state_e;

    localparam int REG_MAX_DEF  = 32;
    localparam int CHANNELS_DEF = 4;
    localparam int ACC_GUARD    = 8;
    localparam int ACC_W        = REG_MAX_DEF + ACC_GUARD;
    localparam int WIDE_W       = 64;

    // Channel index width, never below one bit.
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Arithmetic right shift on a wide signed value; the caller
    // truncates the result to the sample width (wrap, no saturation).
    function automatic logic signed [WIDE_W-1:0] asr_wide(
        input logic signed [WIDE_W-1:0] a,
        input int                       sh
    );
        return a >>> sh;
    endfunction

endpackage

// File: rtl/filter_channel_scheduler_arb.sv
// Round-robin arbiter: one-hot grant plus binary index.
// Ports: clk_i, rst_ni, req_i, grant_en_i -> grant_o, idx_o.
module rr_arbiter
    import filter_sched_pkg::*;
#(
    parameter int N = CHANNELS_DEF,
    parameter int W = chan_w(N)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] req_i,
    input  logic         grant_en_i,
    output logic [N-1:0] grant_o,
    output logic [W-1:0] idx_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;
    logic         found;
    int           c;

    // Scan from the pointer upward, wrapping; first requester wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        c       = 0;
        for (int i = 0; i < N; i++) begin
            c = int'(ptr_q) + i;
            if (c >= N) begin
                c = c - N;
            end
            if (!found && req_i[c]) begin
                found      = 1'b1;
                grant_o[c] = 1'b1;
                idx_o      = W'(c);
            end
        end
        ptr_d = ptr_q;
        if (grant_en_i && found) begin
            if (int'(idx_o) == N - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = idx_o + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/filter_channel_scheduler.sv
// Shares one first-order filter datapath across CHANNELS streams.
// Ports: per-channel in_valid/in_ready/in_data, tagged out stream, busy.
module filter_channel_scheduler
    import filter_sched_pkg::*;
#(
    parameter int REG_MAX  = REG_MAX_DEF,
    parameter int CHANNELS = CHANNELS_DEF,
    parameter int GAIN_1   = 1,
    parameter int GAIN_2   = 16,
    parameter int SHIFT    = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic [CHANNELS-1:0]          in_valid,
    output logic [CHANNELS-1:0]          in_ready,
    input  logic [CHANNELS*REG_MAX-1:0]  in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [REG_MAX-1:0]           out_data,
    output logic [$clog2(CHANNELS)-1:0]  out_chan,
    output logic                         busy
);

    localparam int CW = $clog2(CHANNELS);
    localparam int AW = ACC_W - REG_MAX_DEF + REG_MAX;

    state_e state_q;
    state_e state_d;

    logic [CHANNELS-1:0]        grant;
    logic [CW-1:0]              gidx;
    logic                       accept;

    logic signed [REG_MAX-1:0]  x_q;
    logic [CW-1:0]              g_q;
    logic signed [AW-1:0]       acc_q;
    logic signed [AW-1:0]       acc_d;
    logic signed [REG_MAX-1:0]  y_q [CHANNELS];
    logic signed [REG_MAX-1:0]  p_q [CHANNELS];

    logic signed [REG_MAX-1:0]  x_sel;
    logic signed [REG_MAX-1:0]  y_sel;
    logic signed [REG_MAX-1:0]  p_sel;
    logic signed [AW-1:0]       x_ext;
    logic signed [AW-1:0]       y_ext;
    logic signed [AW-1:0]       p_ext;
    logic signed [REG_MAX-1:0]  y_new;

    logic                       out_valid_q;
    logic [REG_MAX-1:0]         out_data_q;
    logic [CW-1:0]              out_chan_q;

    // No grant while reset is held or clear wins the cycle.
    assign accept = rst_n && !clear
                 && (state_q == IDLE) && (|in_valid);

    assign in_ready = accept ? grant : '0;

    rr_arbiter #(
        .N (CHANNELS),
        .W (CW)
    ) u_arb (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_i      (in_valid),
        .grant_en_i (accept),
        .grant_o    (grant),
        .idx_o      (gidx)
    );

    always_comb begin
        x_sel = '0;
        y_sel = '0;
        p_sel = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (gidx == CW'(k)) begin
                x_sel = in_data[k*REG_MAX +: REG_MAX];
            end
            if (g_q == CW'(k)) begin
                y_sel = y_q[k];
                p_sel = p_q[k];
            end
        end
    end

    // Signed operands widen with sign extension into the accumulator.
    assign x_ext = AW'(x_q);
    assign y_ext = AW'(y_sel);
    assign p_ext = AW'(p_sel);
    assign acc_d = p_ext
                 + AW'(GAIN_1) * x_ext
                 + AW'(GAIN_2) * y_ext;

    assign y_new = REG_MAX'(asr_wide(WIDE_W'(acc_q), SHIFT));

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:  if (accept) state_d = CALC;
                CALC:  state_d = WRITE;
                WRITE: state_d = HOLD;
                HOLD:  if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q         <= '0;
            g_q         <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                y_q[k] <= '0;
                p_q[k] <= '0;
            end
        end else if (clear) begin
            out_valid_q <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                y_q[k] <= '0;
                p_q[k] <= '0;
            end
        end else begin
            if (accept) begin
                x_q <= x_sel;
                g_q <= gidx;
            end
            if (state_q == CALC) begin
                acc_q <= acc_d;
            end
            if (state_q == WRITE) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    if (g_q == CW'(k)) begin
                        y_q[k] <= y_new;
                        p_q[k] <= y_q[k];
                    end
                end
                out_data_q  <= y_new;
                out_chan_q  <= g_q;
                out_valid_q <= 1'b1;
            end
            if (state_q == HOLD && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_filter_channel_scheduler.sv
// Directed bench for filter_channel_scheduler.
// Four channels, 32-bit samples, gains 1/16, shift 4.
module tb_filter_channel_scheduler;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clear = 1'b0;
    logic [3:0]   in_valid = '0;
    logic [3:0]   in_ready;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [31:0]  out_data;
    logic [1:0]   out_chan;
    logic         busy;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    filter_channel_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .busy      (busy)
    );

    task automatic apply_reset();
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        clear     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Offer one sample on channel ch; return result, tag and the
    // number of sampled cycles from accept to out_valid.
    task automatic do_op(
        input  int          ch,
        input  logic [31:0] x,
        output logic [31:0] d,
        output logic [1:0]  c,
        output int          lat
    );
        int n;
        in_data[ch*32 +: 32] = x;
        in_valid = 4'b0001 << ch;
        n = 0;
        #1;
        while (!in_ready[ch] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = '0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        d = out_data;
        c = out_chan;
        if (!out_valid || n >= 20) lat = 99;
    endtask

    task automatic test_reset();
        in_valid = 4'hF;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 4'h0)
            $display("FAIL rst_in_ready: got %h want 0", in_ready);
        else passed++;
        checks++;
        if (out_valid !== 1'b0)
            $display("FAIL rst_out_valid: got %b want 0", out_valid);
        else passed++;
        checks++;
        if (out_data !== 32'h0 || out_chan !== 2'd0)
            $display("FAIL rst_out: got %h/%0d want 0/0",
                     out_data, out_chan);
        else passed++;
        checks++;
        if (busy !== 1'b0)
            $display("FAIL rst_busy: got %b want 0", busy);
        else passed++;
        in_valid = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] exp_d [3];
        logic [31:0] d;
        logic [1:0]  c;
        int          lat;
        exp_d = '{32'd1, 32'd2, 32'd3};
        for (int i = 0; i < 3; i++) begin
            do_op(0, 32'd16, d, c, lat);
            checks++;
            if (d !== exp_d[i])
                $display("FAIL basic%0d_data: got %h want %h",
                         i, d, exp_d[i]);
            else passed++;
            checks++;
            if (c !== 2'd0)
                $display("FAIL basic%0d_chan: got %0d want 0", i, c);
            else passed++;
            checks++;
            if (lat != 3)
                $display("FAIL basic%0d_lat: got %0d want 3", i, lat);
            else passed++;
        end
    endtask

    task automatic test_negative();
        logic [31:0] exp_d [3];
        logic [31:0] xs [3];
        logic [31:0] d;
        logic [1:0]  c;
        int          lat;
        xs    = '{32'hFFFF_FFE0, 32'h0, 32'h0};
        exp_d = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFD};
        for (int i = 0; i < 3; i++) begin
            do_op(2, xs[i], d, c, lat);
            checks++;
            if (d !== exp_d[i] || c !== 2'd2)
                $display("FAIL neg%0d: got %h/%0d want %h/2",
                         i, d, c, exp_d[i]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int cyc [8];
        int gnt [8];
        int ecyc [5];
        int egnt [5];
        int nacc;
        int bad_oh;
        ecyc = '{0, 4, 8, 12, 16};
        egnt = '{0, 1, 2, 3, 0};
        apply_reset();
        in_data  = {4{32'd16}};
        in_valid = 4'hF;
        nacc   = 0;
        bad_oh = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (in_ready !== 4'h0) begin
                if (!$onehot(in_ready)) bad_oh++;
                if (nacc < 8) begin
                    cyc[nacc] = i;
                    gnt[nacc] = 0;
                    for (int k = 0; k < 4; k++)
                        if (in_ready[k]) gnt[nacc] = k;
                end
                nacc++;
            end
            @(negedge clk);
        end
        in_valid = '0;
        checks++;
        if (nacc != 5)
            $display("FAIL b2b_count: got %0d want 5", nacc);
        else passed++;
        checks++;
        if (bad_oh != 0)
            $display("FAIL b2b_onehot: got %0d bad want 0", bad_oh);
        else passed++;
        for (int j = 0; j < 5; j++) begin
            if (j < nacc) begin
                checks++;
                if (cyc[j] != ecyc[j] || gnt[j] != egnt[j])
                    $display("FAIL b2b%0d: got cyc %0d ch %0d want %0d ch %0d",
                             j, cyc[j], gnt[j], ecyc[j], egnt[j]);
                else passed++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        logic [1:0]  c;
        int          lat;
        int          bad;
        apply_reset();
        out_ready = 1'b0;
        do_op(3, 32'd16, d, c, lat);
        checks++;
        if (d !== 32'd1 || c !== 2'd3 || lat != 3)
            $display("FAIL bp_first: got %h/%0d/%0d want 1/3/3",
                     d, c, lat);
        else passed++;
        in_data[32 +: 32] = 32'd32;
        in_valid = 4'b0010;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!out_valid || out_data !== 32'd1
                || out_chan !== 2'd3 || in_ready !== 4'h0
                || !busy) bad++;
        end
        checks++;
        if (bad != 0)
            $display("FAIL bp_hold: got %0d bad cycles want 0", bad);
        else passed++;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 4'b0010 || out_valid !== 1'b0)
            $display("FAIL bp_next: got ready %h valid %b want 2/0",
                     in_ready, out_valid);
        else passed++;
        @(posedge clk);
        #1;
        in_valid = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (!out_valid || out_data !== 32'd2 || out_chan !== 2'd1)
            $display("FAIL bp_second: got %b/%h/%0d want 1/2/1",
                     out_valid, out_data, out_chan);
        else passed++;
    endtask

    task automatic test_clear();
        logic [31:0] d;
        logic [1:0]  c;
        int          lat;
        int          bad;
        int          n;
        apply_reset();
        do_op(1, 32'd16, d, c, lat);
        checks++;
        if (d !== 32'd1 || c !== 2'd1)
            $display("FAIL clr_pre: got %h/%0d want 1/1", d, c);
        else passed++;
        in_valid = 4'b0010;
        n = 0;
        #1;
        while (!in_ready[1] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = '0;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid || busy) bad++;
        end
        checks++;
        if (bad != 0 || n >= 20)
            $display("FAIL clr_calc: got %0d bad cycles want 0", bad);
        else passed++;
        in_valid = 4'b0001;
        clear = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'h0)
            $display("FAIL clr_ready: got %h want 0", in_ready);
        else passed++;
        @(posedge clk);
        #1;
        clear = 1'b0;
        in_valid = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0)
            $display("FAIL clr_idle: got busy %b want 0", busy);
        else passed++;
        do_op(1, 32'd16, d, c, lat);
        checks++;
        if (d !== 32'd1 || c !== 2'd1)
            $display("FAIL clr_post: got %h/%0d want 1/1", d, c);
        else passed++;
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        logic [1:0]  c;
        int          lat;
        apply_reset();
        do_op(2, 32'd16, d, c, lat);
        out_ready = 1'b0;
        do_op(0, 32'd16, d, c, lat);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0
            || out_chan !== 2'd0 || busy !== 1'b0)
            $display("FAIL arst_out: got %b/%h/%0d/%b want 0/0/0/0",
                     out_valid, out_data, out_chan, busy);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        do_op(0, 32'd16, d, c, lat);
        checks++;
        if (d !== 32'd1 || c !== 2'd0 || lat != 3)
            $display("FAIL arst_post: got %h/%0d/%0d want 1/0/3",
                     d, c, lat);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_back_to_back();
        test_backpressure();
        test_clear();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

endmodule
